// File: rtl/vga_pkg.sv
// Shared VGA-pipeline types and constants, used by the arbiter, line engines and vga.
package vga_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int PIXEL_W           = 16;
  localparam int DEFAULT_MAX_BURST = 64;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating-priority encoder: first set bit of req scanning ptr, ptr+1, ... mod N.
module rr_pick #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] cand;

  // Walk the rotation from farthest to nearest so the nearest hit is the one kept.
  always_comb begin
    valid = |req;
    index = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (req[cand]) index = cand;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the VGA pixel-FIFO write port between N drawing engines,
// with a per-grant word limit and frame-start restart on vtrigger.
module fifo_write_arbiter
  import vga_pkg::*;
#(
  parameter int N         = 2,
  parameter int DATA_W    = PIXEL_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int CNT_W     = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vtrigger,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        req_write,
  input  logic [N-1:0]        req_last,
  input  logic [N*DATA_W-1:0] req_data,
  output logic [N-1:0]        req_full,
  output logic [N-1:0]        gnt,
  input  logic                fifo_full,
  output logic                fifo_write,
  output logic [DATA_W-1:0]   fifo_data,
  output logic [CNT_W-1:0]    frame_words,
  output logic                proto_err
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int BC_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  arb_state_t       state, next_state;
  logic [IDX_W-1:0] g_idx, ptr, pick_idx;
  logic [BC_W-1:0]  burst_cnt;
  logic             pick_valid, accept, release_g, proto_hit;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (vtrigger)                              next_state = IDLE;
    else if (state == IDLE && pick_valid)      next_state = GRANT;
    else if (state == GRANT && release_g)      next_state = IDLE;
  end

  // req_full is all ones outside GRANT because gnt is zero there.
  always_comb begin
    accept     = (state == GRANT) && req_write[g_idx] && !fifo_full;
    release_g  = (state == GRANT) &&
                 ((accept && req_last[g_idx]) ||
                  (accept && burst_cnt == BC_W'(MAX_BURST - 1)) ||
                  !req[g_idx]);
    fifo_write = accept;
    fifo_data  = req_data[int'(g_idx) * DATA_W +: DATA_W];
    req_full   = ~gnt | {N{fifo_full}};
    proto_hit  = |(req_write & req_full);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= '0;
      g_idx     <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else if (vtrigger) begin
      gnt       <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (pick_valid) begin
        gnt       <= N'(1) << pick_idx;
        g_idx     <= pick_idx;
        burst_cnt <= '0;
      end
    end else if (release_g) begin
      gnt       <= '0;
      ptr       <= (g_idx == IDX_W'(N - 1)) ? '0 : g_idx + 1'b1;
      burst_cnt <= '0;
    end else if (accept) begin
      burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // A word accepted in the vtrigger cycle belongs to the new frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_words <= '0;
      proto_err   <= 1'b0;
    end else if (vtrigger) begin
      frame_words <= accept ? CNT_W'(1) : '0;
      proto_err   <= 1'b0;
    end else begin
      if (accept && frame_words != '1) frame_words <= frame_words + 1'b1;
      if (proto_hit)                   proto_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: N=2, MAX_BURST=4, 3-bit frame counter to reach saturation.
module tb_fifo_write_arbiter;

  logic        clk;
  logic        reset;
  logic        vtrigger;
  logic [1:0]  req, req_write, req_last;
  logic [31:0] req_data;
  logic [1:0]  req_full, gnt;
  logic        fifo_full;
  logic        fifo_write;
  logic [15:0] fifo_data;
  logic [2:0]  frame_words;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  fifo_write_arbiter #(.N(2), .DATA_W(16), .MAX_BURST(4), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .vtrigger    (vtrigger),
    .req         (req),
    .req_write   (req_write),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_full    (req_full),
    .gnt         (gnt),
    .fifo_full   (fifo_full),
    .fifo_write  (fifo_write),
    .fifo_data   (fifo_data),
    .frame_words (frame_words),
    .proto_err   (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slot 1 always carries the slot-0 word plus 0x1000 so the mux source is visible.
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                               input logic [15:0] d);
    req       = r;
    req_write = w;
    req_last  = l;
    req_data  = {d + 16'h1000, d};
  endtask

  task automatic expectGrant(input int who);
    tick();
    checkOutput("gnt_on", {30'b0, gnt}, 32'(1 << who));
  endtask

  task automatic sendWords(input int who, input int n, input bit withLast, input logic [15:0] base);
    logic [1:0] sel;
    sel = 2'(1 << who);
    for (int k = 0; k < n; k++) begin
      applyStimulus(req, sel, (withLast && k == n - 1) ? sel : 2'b00, base + 16'(k));
      #1;
      checkOutput("fifo_write", {31'b0, fifo_write}, 32'd1);
      checkOutput("fifo_data", {16'b0, fifo_data}, {16'b0, base + 16'(k) + (who == 1 ? 16'h1000 : 16'h0)});
      tick();
    end
    req_write = 2'b00;
    req_last  = 2'b00;
  endtask

  initial begin
    reset     = 1'b0;
    vtrigger  = 1'b0;
    fifo_full = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00, 16'h0);
    #3;
    checkOutput("rst_gnt", {30'b0, gnt}, 32'd0);
    checkOutput("rst_fifo_write", {31'b0, fifo_write}, 32'd0);
    checkOutput("rst_req_full", {30'b0, req_full}, 32'd3);
    checkOutput("rst_frame_words", {29'b0, frame_words}, 32'd0);
    checkOutput("rst_proto_err", {31'b0, proto_err}, 32'd0);
    reset = 1'b1;

    // Single requester, 3-word burst ending on last.
    tick();
    req = 2'b01;
    #1;
    checkOutput("t1_gnt_idle", {30'b0, gnt}, 32'd0);
    expectGrant(0);
    sendWords(0, 3, 1'b1, 16'hA000);
    req = 2'b00;
    checkOutput("t1_gnt_rel", {30'b0, gnt}, 32'd0);
    checkOutput("t1_frame_words", {29'b0, frame_words}, 32'd3);
    tick();

    // Both requesting: ptr=1 after the previous grant, so order is 1,0,1.
    req = 2'b11;
    expectGrant(1);
    sendWords(1, 3, 1'b1, 16'h0100);
    checkOutput("t2_idle_a", {30'b0, gnt}, 32'd0);
    expectGrant(0);
    sendWords(0, 3, 1'b1, 16'h0200);
    checkOutput("t2_idle_b", {30'b0, gnt}, 32'd0);
    expectGrant(1);
    sendWords(1, 3, 1'b1, 16'h0300);
    checkOutput("t2_idle_c", {30'b0, gnt}, 32'd0);
    checkOutput("t2_frame_sat", {29'b0, frame_words}, 32'd7);

    // Burst limit: req0 streams without last and is cut after 4 words.
    expectGrant(0);
    sendWords(0, 4, 1'b0, 16'h0400);
    checkOutput("t3_limit_rel", {30'b0, gnt}, 32'd0);
    expectGrant(1);
    sendWords(1, 2, 1'b1, 16'h0500);
    checkOutput("t3_idle", {30'b0, gnt}, 32'd0);
    expectGrant(0);

    // Stall mid-burst: 1 word, 3 full cycles, then 3 words must complete the 4-word limit.
    sendWords(0, 1, 1'b0, 16'h0600);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("t4_stall_write", {31'b0, fifo_write}, 32'd0);
      checkOutput("t4_stall_full", {30'b0, req_full}, 32'd3);
      checkOutput("t4_stall_gnt", {30'b0, gnt}, 32'd1);
      tick();
    end
    fifo_full = 1'b0;
    checkOutput("t4_gnt_held", {30'b0, gnt}, 32'd1);
    sendWords(0, 3, 1'b0, 16'h0601);
    checkOutput("t4_limit_rel", {30'b0, gnt}, 32'd0);
    checkOutput("t4_proto_err", {31'b0, proto_err}, 32'd0);

    // vtrigger with an accepted word in the same cycle.
    expectGrant(1);
    sendWords(1, 1, 1'b0, 16'h0700);
    applyStimulus(2'b11, 2'b10, 2'b00, 16'h0701);
    vtrigger = 1'b1;
    #1;
    checkOutput("t5_vt_write", {31'b0, fifo_write}, 32'd1);
    checkOutput("t5_vt_data", {16'b0, fifo_data}, 32'h1701);
    tick();
    vtrigger  = 1'b0;
    req_write = 2'b00;
    checkOutput("t5_vt_gnt", {30'b0, gnt}, 32'd0);
    checkOutput("t5_vt_frame", {29'b0, frame_words}, 32'd1);
    expectGrant(0);

    // Protocol error: requester 1 writes while not granted.
    applyStimulus(2'b11, 2'b10, 2'b00, 16'h0800);
    #1;
    checkOutput("t6_drop_write", {31'b0, fifo_write}, 32'd0);
    tick();
    req_write = 2'b00;
    checkOutput("t6_proto_set", {31'b0, proto_err}, 32'd1);
    checkOutput("t6_frame_keep", {29'b0, frame_words}, 32'd1);
    tick();
    checkOutput("t6_proto_hold", {31'b0, proto_err}, 32'd1);
    checkOutput("t6_gnt_hold", {30'b0, gnt}, 32'd1);
    req = 2'b10;
    tick();
    checkOutput("t6_req_drop_rel", {30'b0, gnt}, 32'd0);
    vtrigger = 1'b1;
    tick();
    vtrigger = 1'b0;
    checkOutput("t6_proto_clr", {31'b0, proto_err}, 32'd0);
    checkOutput("t6_frame_clr", {29'b0, frame_words}, 32'd0);
    expectGrant(1);
    sendWords(1, 1, 1'b0, 16'h0900);
    checkOutput("t6_frame_one", {29'b0, frame_words}, 32'd1);

    // Asynchronous reset mid-burst.
    applyStimulus(2'b10, 2'b10, 2'b00, 16'h0901);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t7_rst_gnt", {30'b0, gnt}, 32'd0);
    checkOutput("t7_rst_write", {31'b0, fifo_write}, 32'd0);
    checkOutput("t7_rst_full", {30'b0, req_full}, 32'd3);
    checkOutput("t7_rst_frame", {29'b0, frame_words}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
